// File: rtl/fault_sweep_pkg.sv
// Shared types for the fault sweep engine: FSM states, the fault-free opcode
// and the mismatch report record (sized for the default engine configuration).
package fault_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_REPORT,
        S_SUMMARY,
        S_DONE
    } state_t;

    localparam int OPC_W_DEF = 6;
    localparam int REC_IDX_W = 5;
    localparam int REC_VEC_W = 5;
    localparam int REC_OUT_W = 2;

    localparam logic [OPC_W_DEF-1:0] OPC_NOFAULT = '0;

    typedef struct packed {
        logic [REC_IDX_W-1:0] fault_idx;
        logic [REC_VEC_W-1:0] vector;
        logic [REC_OUT_W-1:0] out;
    } rpt_rec_t;

endpackage

// File: rtl/fault_sweep_golden_ram.sv
// Fault-free response store: one synchronous write port, one combinational read port.
module fault_sweep_golden_ram #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fault_sweep_engine.sv
// Fault-simulation sequencer: golden sweep, then one sweep per fault table entry,
// streaming mismatches on a valid/ready channel and pulsing a per-fault summary.
module fault_sweep_engine
    import fault_sweep_pkg::*;
#(
    parameter int N_IN       = REC_VEC_W,
    parameter int N_OUT      = REC_OUT_W,
    parameter int OPC_W      = OPC_W_DEF,
    parameter int MAX_FAULTS = 32,
    parameter int SETTLE     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(MAX_FAULTS+1)-1:0] num_faults,
    input  logic                            fault_drop,
    input  logic                            flt_wr_en,
    input  logic [$clog2(MAX_FAULTS)-1:0]   flt_wr_addr,
    input  logic [OPC_W-1:0]                flt_wr_opcode,
    output logic [N_IN-1:0]                 dut_in,
    output logic [OPC_W-1:0]                dut_opcode,
    input  logic [N_OUT-1:0]                dut_out,
    output logic                            rpt_valid,
    input  logic                            rpt_ready,
    output logic [$clog2(MAX_FAULTS)-1:0]   rpt_fault_idx,
    output logic [N_IN-1:0]                 rpt_vector,
    output logic [N_OUT-1:0]                rpt_out,
    output logic                            sum_valid,
    output logic [$clog2(MAX_FAULTS)-1:0]   sum_fault_idx,
    output logic [N_IN:0]                   sum_detect_cnt,
    output logic                            busy,
    output logic                            done
);

    localparam int IDX_W      = $clog2(MAX_FAULTS);
    localparam int NF_W       = $clog2(MAX_FAULTS + 1);
    localparam int SETTLE_CYC = (SETTLE > 0) ? SETTLE : 1;
    localparam int ST_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [NF_W-1:0] NF_MAX      = NF_W'(MAX_FAULTS);

    state_t            state;
    logic              golden_phase;
    logic              drop;
    logic [N_IN-1:0]   vec;
    logic [NF_W-1:0]   nf;
    logic [IDX_W-1:0]  fidx;
    logic [N_IN:0]     cnt;
    logic [ST_W-1:0]   settle_cnt;
    rpt_rec_t          rec;
    logic [OPC_W-1:0]  fault_tbl [MAX_FAULTS];
    logic [N_OUT-1:0]  golden_rd;
    logic              golden_we;
    logic              mismatch;
    logic              more_faults;
    logic [IDX_W-1:0]  fidx_next;
    logic [NF_W-1:0]   nf_clamped;

    assign nf_clamped  = (num_faults > NF_MAX) ? NF_MAX : num_faults;
    assign fidx_next   = fidx + 1'b1;
    assign more_faults = (NF_W'(fidx) + NF_W'(1)) < nf;
    assign golden_we   = (state == S_SAMPLE) && golden_phase;
    assign mismatch    = !golden_phase && (golden_rd != dut_out);

    assign dut_in        = vec;
    assign rpt_fault_idx = rec.fault_idx;
    assign rpt_vector    = rec.vector;
    assign rpt_out       = rec.out;

    fault_sweep_golden_ram #(
        .AW (N_IN),
        .DW (N_OUT)
    ) u_golden (
        .clk   (clk),
        .we    (golden_we),
        .waddr (vec),
        .wdata (dut_out),
        .raddr (vec),
        .rdata (golden_rd)
    );

    always_ff @(posedge clk) begin
        if (flt_wr_en && (state == S_IDLE)) fault_tbl[flt_wr_addr] <= flt_wr_opcode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            golden_phase   <= 1'b0;
            drop           <= 1'b0;
            vec            <= '0;
            nf             <= '0;
            fidx           <= '0;
            cnt            <= '0;
            settle_cnt     <= SETTLE_LOAD;
            rec            <= '0;
            dut_opcode     <= OPC_NOFAULT;
            rpt_valid      <= 1'b0;
            sum_valid      <= 1'b0;
            sum_fault_idx  <= '0;
            sum_detect_cnt <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            sum_valid  <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nf           <= nf_clamped;
                        drop         <= fault_drop;
                        golden_phase <= 1'b1;
                        vec          <= '0;
                        dut_opcode   <= OPC_NOFAULT;
                        busy         <= 1'b1;
                        state        <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (settle_cnt == '0) state <= S_SAMPLE;
                    else settle_cnt <= settle_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        cnt       <= cnt + 1'b1;
                        rec       <= '{fault_idx: fidx, vector: vec, out: dut_out};
                        rpt_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else if (vec != VEC_LAST) begin
                        vec   <= vec + 1'b1;
                        state <= S_APPLY;
                    end else if (golden_phase) begin
                        if (nf != '0) begin
                            golden_phase <= 1'b0;
                            fidx         <= '0;
                            cnt          <= '0;
                            vec          <= '0;
                            dut_opcode   <= fault_tbl[0];
                            state        <= S_APPLY;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        sum_valid      <= 1'b1;
                        sum_fault_idx  <= fidx;
                        sum_detect_cnt <= cnt;
                        state          <= S_SUMMARY;
                    end
                end
                S_REPORT: begin
                    // record stays frozen until the consumer takes it
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        if (drop || (vec == VEC_LAST)) begin
                            sum_valid      <= 1'b1;
                            sum_fault_idx  <= fidx;
                            sum_detect_cnt <= cnt;
                            state          <= S_SUMMARY;
                        end else begin
                            vec   <= vec + 1'b1;
                            state <= S_APPLY;
                        end
                    end
                end
                S_SUMMARY: begin
                    if (more_faults) begin
                        fidx       <= fidx_next;
                        cnt        <= '0;
                        vec        <= '0;
                        dut_opcode <= fault_tbl[fidx_next];
                        state      <= S_APPLY;
                    end else begin
                        dut_opcode <= OPC_NOFAULT;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    vec   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
